cdb_grant_controller: RTL and testbench
=======================================

Name: cdb_grant_controller

Overview:
- Central grant side of the common data bus (CDB) arbitration handshake.
- Execution combos each contain an arbiter. An arbiter raises a bus request and watches the two CDB select lines for its own address.
- This block collects all requests and picks up to two distinct requesters per cycle, using round-robin fairness.
- It drives the winners' addresses onto select of CDB 0 and CDB 1. It sits beside the two CDB instances in the core top level.

Parameters:
- NUM_REQ, 8: number of requesting combos (2..16).
- ADDR_BASE, 8'h01: arbiter address of requester 0. Requester i has address ADDR_BASE+i.
- IDLE_ADDR, 8'hFF: select value meaning "no owner". It must not equal any requester address.

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous, active-low reset.
- get_bus  input  NUM_REQ  bit i is requester i asking for one CDB broadcast slot.
- select_0  output  8  owner address of CDB 0, registered.
- select_1  output  8  owner address of CDB 1, registered.
- grant_valid  output  2  bit b = select_b holds a requester address (not IDLE_ADDR), registered.
- grant_vec  output  NUM_REQ  one-hot or two-hot mask of requesters granted this cycle, registered.

Behaviour:
- Reset (reset low, asynchronous):
  - select_0 = select_1 = IDLE_ADDR.
  - grant_valid = 0, grant_vec = 0.
  - rr_ptr = 0, cooldown = 0.
  - Reset deassertion takes effect on the next clk rising edge. A reset mid-grant discards that grant; the requester keeps get_bus high and is re-arbitrated.
- Handshake per requester:
  - Cycle t: requester raises get_bus[i].
  - Cycle t+1 at the earliest: select_b == ADDR_BASE+i, and the requester broadcasts on CDB b during that cycle.
  - The requester may keep get_bus high if it has another result; otherwise it drops it in t+2.
  - A slot is exactly one cycle. Grants are never held.
- Cooldown: cooldown is a register equal to last cycle's grant_vec. Requesters in cooldown are ineligible this cycle. This covers the one-cycle lag before a served requester drops get_bus, so a single result is never granted twice.
  - Consequence: a requester with back-to-back results gets at most one slot every 2 cycles.
- Arbitration, combinational on registered inputs:
  - eligible = get_bus & ~cooldown.
  - Scan indices rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - The first eligible index found goes to CDB 0; the second goes to CDB 1.
  - Both selects, grant_valid and grant_vec are registered at the clk edge. Latency is 1 cycle.
- Pointer update:
  - Two winners: rr_ptr = (second winner + 1) mod NUM_REQ.
  - One winner: rr_ptr = (that index + 1) mod NUM_REQ.
  - No winner: rr_ptr is unchanged.
- Boundaries:
  - 0 eligible: both selects = IDLE_ADDR, grant_valid = 2'b00.
  - 1 eligible: only CDB 0 is used, select_1 = IDLE_ADDR, grant_valid = 2'b01.
  - The same requester never appears on both buses in one cycle.
- Wrap-around:
  - The scan wraps from NUM_REQ-1 to 0.
  - Address arithmetic is 8-bit.
- Fairness: a continuously requesting requester is granted within ceil(NUM_REQ/2)+1 cycles of becoming eligible.

Test Plan (NUM_REQ=4, ADDR_BASE=8'h01, IDLE_ADDR=8'hFF):
- Reset:
  - Stimulus: assert reset low mid-cycle with get_bus=4'b1111.
  - Required: outputs immediately select_0 = select_1 = 8'hFF, grant_valid = 0.
  - After release: first grant is select_0 = 8'h01, select_1 = 8'h02.
- Single request:
  - Stimulus: get_bus[2] pulsed high for one cycle at t.
  - Required: at t+1, select_0 = 8'h03, select_1 = 8'hFF, grant_valid = 2'b01, grant_vec = 4'b0100. Then idle.
- Cooldown:
  - Stimulus: get_bus[0] held high for 6 cycles, others low.
  - Required: select_0 alternates 8'h01, 8'hFF, 8'h01, ... There is never a grant in two consecutive cycles.
- Round-robin:
  - Stimulus: get_bus = 4'b1111 held.
  - Required: grant pairs cycle through (01,02), (03,04), (01,02), ...
  - rr_ptr wraps 0 → 2 → 0.
  - No requester waits more than 3 cycles.
- Wrap scan:
  - Setup: rr_ptr = 3 (after granting requesters 1 and 2).
  - Stimulus: get_bus = 4'b1001.
  - Required: select_0 = 8'h04, select_1 = 8'h01, rr_ptr becomes 1.
- Late arrival:
  - Stimulus: get_bus[1] rises in the same cycle that requester 0 is granted.
  - Required: requester 1 is granted on the next edge on CDB 0. Requester 0 is not re-granted in that cycle.

Source files
------------

// File: rtl/cdb_grant_controller.sv
`default_nettype none
// ============================================================================
// Module      : cdb_grant_controller
// Description : Central grant side of the common data bus (CDB) arbitration
//               handshake. Collects bus requests from the execution-combo
//               arbiters. Each cycle it picks up to two distinct requesters
//               in round-robin order and drives their arbiter addresses onto
//               the select lines of CDB 0 and CDB 1.
//
// Ports       : clk          - core clock
//               reset        - asynchronous, active-low reset
//               get_bus      - [NUM_REQ] bit i = requester i wants one slot
//               select_0     - [8] owner address of CDB 0 (registered)
//               select_1     - [8] owner address of CDB 1 (registered)
//               grant_valid  - [2] bit b = select_b holds a real owner
//               grant_vec    - [NUM_REQ] requesters granted this cycle
//
// Parameters  : NUM_REQ   - number of requesting combos (2..16)
//               ADDR_BASE - arbiter address of requester 0
//               IDLE_ADDR - select value meaning "no owner"
//
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_grant_controller #(
    parameter int         NUM_REQ   = 8,
    parameter logic [7:0] ADDR_BASE = 8'h01,
    parameter logic [7:0] IDLE_ADDR = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] get_bus,
    output logic [7:0]         select_0,
    output logic [7:0]         select_1,
    output logic [1:0]         grant_valid,
    output logic [NUM_REQ-1:0] grant_vec
);

    // Pointer width; one extra bit is used for the unwrapped sums below.
    localparam int                 c_PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam logic [c_PTR_W:0]   c_NUM   = (c_PTR_W+1)'(NUM_REQ);
    localparam logic [c_PTR_W:0]   c_ONE   = (c_PTR_W+1)'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_PTR_W-1:0] r_rr_ptr;
    logic [7:0]         r_select_0;
    logic [7:0]         r_select_1;
    logic [1:0]         r_grant_valid;
    logic [NUM_REQ-1:0] r_grant_vec;

    // The cooldown mask is by definition last cycle's grant vector, which is
    // exactly what r_grant_vec holds while the served requesters are still
    // broadcasting. A requester sees its grant one cycle late, so its
    // get_bus is still high at the next edge; masking it here keeps a single
    // result from being granted twice.
    logic [NUM_REQ-1:0] w_cooldown;
    logic [NUM_REQ-1:0] w_eligible;

    assign w_cooldown = r_grant_vec;
    assign w_eligible = get_bus & ~w_cooldown;

    // ------------------------------------------------------------------------
    // Scan order: w_scan_idx[k] = (rr_ptr + k) mod NUM_REQ.
    // rr_ptr and k are both below NUM_REQ, so one conditional subtract wraps.
    // ------------------------------------------------------------------------
    logic [c_PTR_W-1:0] w_scan_idx [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_scan
        logic [c_PTR_W:0] w_sum;
        logic [c_PTR_W:0] w_wrapped;

        assign w_sum         = {1'b0, r_rr_ptr} + (c_PTR_W+1)'(k);
        assign w_wrapped     = (w_sum >= c_NUM) ? (w_sum - c_NUM) : w_sum;
        assign w_scan_idx[k] = w_wrapped[c_PTR_W-1:0];
    end

    // ------------------------------------------------------------------------
    // Pick the first and second eligible requesters in scan order.
    // Because each index occurs once in the scan, the two winners are
    // always distinct.
    // ------------------------------------------------------------------------
    logic               w_first_found;
    logic               w_second_found;
    logic [c_PTR_W-1:0] w_first_idx;
    logic [c_PTR_W-1:0] w_second_idx;

    always_comb begin
        w_first_found  = 1'b0;
        w_second_found = 1'b0;
        w_first_idx    = '0;
        w_second_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_eligible[w_scan_idx[k]]) begin
                if (!w_first_found) begin
                    w_first_found = 1'b1;
                    w_first_idx   = w_scan_idx[k];
                end else if (!w_second_found) begin
                    w_second_found = 1'b1;
                    w_second_idx   = w_scan_idx[k];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next round-robin pointer: one past the last winner, unchanged when idle.
    // ------------------------------------------------------------------------
    logic [c_PTR_W-1:0] w_last_idx;
    logic [c_PTR_W:0]   w_last_inc;
    logic [c_PTR_W-1:0] w_ptr_wrap;
    logic [c_PTR_W-1:0] w_ptr_next;

    assign w_last_idx = w_second_found ? w_second_idx : w_first_idx;
    assign w_last_inc = {1'b0, w_last_idx} + c_ONE;
    assign w_ptr_wrap = (w_last_inc == c_NUM) ? '0 : w_last_inc[c_PTR_W-1:0];
    assign w_ptr_next = w_first_found ? w_ptr_wrap : r_rr_ptr;

    // ------------------------------------------------------------------------
    // Next grant mask, addresses and valid bits. Address math is 8-bit.
    // ------------------------------------------------------------------------
    logic [NUM_REQ-1:0] w_grant_next;
    logic [7:0]         w_select_0_next;
    logic [7:0]         w_select_1_next;
    logic [1:0]         w_valid_next;

    always_comb begin
        w_grant_next = '0;
        if (w_first_found) begin
            w_grant_next[w_first_idx] = 1'b1;
        end
        if (w_second_found) begin
            w_grant_next[w_second_idx] = 1'b1;
        end
    end

    assign w_select_0_next = w_first_found  ? (ADDR_BASE + 8'(w_first_idx))  : IDLE_ADDR;
    assign w_select_1_next = w_second_found ? (ADDR_BASE + 8'(w_second_idx)) : IDLE_ADDR;
    assign w_valid_next    = {w_second_found, w_first_found};

    // ------------------------------------------------------------------------
    // Registers. A slot lasts exactly one cycle: every edge reloads the
    // outputs from the fresh arbitration, so grants are never held.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr      <= '0;
            r_select_0    <= IDLE_ADDR;
            r_select_1    <= IDLE_ADDR;
            r_grant_valid <= 2'b00;
            r_grant_vec   <= '0;
        end else begin
            r_rr_ptr      <= w_ptr_next;
            r_select_0    <= w_select_0_next;
            r_select_1    <= w_select_1_next;
            r_grant_valid <= w_valid_next;
            r_grant_vec   <= w_grant_next;
        end
    end

    assign select_0    = r_select_0;
    assign select_1    = r_select_1;
    assign grant_valid = r_grant_valid;
    assign grant_vec   = r_grant_vec;

endmodule
`default_nettype wire

// File: tb/tb_cdb_grant_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_grant_controller
// Description : Self-checking bench for cdb_grant_controller with NUM_REQ=4,
//               ADDR_BASE=8'h01, IDLE_ADDR=8'hFF. Directed vector table,
//               hand-written reset sequence, then random requests compared
//               against a queue-based round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_grant_controller;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] gb = '0;
    logic [7:0]   select_0;
    logic [7:0]   select_1;
    logic [1:0]   grant_valid;
    logic [N-1:0] grant_vec;

    int n_checks = 0;
    int n_err    = 0;

    cdb_grant_controller #(
        .NUM_REQ   (N),
        .ADDR_BASE (8'h01),
        .IDLE_ADDR (8'hFF)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .get_bus     (gb),
        .select_0    (select_0),
        .select_1    (select_1),
        .grant_valid (grant_valid),
        .grant_vec   (grant_vec)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model: list eligible requesters in rotation order from the
    // pointer, hand the first two to CDB 0 / CDB 1.
    // ------------------------------------------------------------------------
    int           m_ptr  = 0;
    logic [N-1:0] m_cool = '0;
    logic [7:0]   e_s0;
    logic [7:0]   e_s1;
    logic [1:0]   e_gv;
    logic [N-1:0] e_gvec;

    task automatic model_step(input logic [N-1:0] req);
        int q[$];
        q = {};
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (req[i] && !m_cool[i]) q.push_back(i);
        end
        e_s0 = 8'hFF; e_s1 = 8'hFF; e_gv = 2'b00; e_gvec = '0;
        if (q.size() > 0) begin
            e_s0 = 8'(1 + q[0]); e_gv[0] = 1'b1; e_gvec[q[0]] = 1'b1;
            m_ptr = (q[0] + 1) % N;
        end
        if (q.size() > 1) begin
            e_s1 = 8'(1 + q[1]); e_gv[1] = 1'b1; e_gvec[q[1]] = 1'b1;
            m_ptr = (q[1] + 1) % N;
        end
        m_cool = e_gvec;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                           input logic [1:0] gv, input logic [N-1:0] gvec);
        chk({tag, " select_0"},    32'(select_0),    32'(s0));
        chk({tag, " select_1"},    32'(select_1),    32'(s1));
        chk({tag, " grant_valid"}, 32'(grant_valid), 32'(gv));
        chk({tag, " grant_vec"},   32'(grant_vec),   32'(gvec));
    endtask

    // Drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic apply(input logic [N-1:0] v);
        @(negedge clk);
        gb = v;
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [N-1:0] gb;
        logic [7:0]   s0;
        logic [7:0]   s1;
        logic [1:0]   gv;
        logic [N-1:0] gvec;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl [NV];

    initial begin
        // Directed sequence from reset (pointer 0, no cooldown).
        // Round-robin with all requesting.
        tbl[0]  = '{4'b1111, 8'h01, 8'h02, 2'b11, 4'b0011};
        tbl[1]  = '{4'b1111, 8'h03, 8'h04, 2'b11, 4'b1100};
        tbl[2]  = '{4'b1111, 8'h01, 8'h02, 2'b11, 4'b0011};
        tbl[3]  = '{4'b0000, 8'hFF, 8'hFF, 2'b00, 4'b0000};
        // Single one-cycle request from requester 2.
        tbl[4]  = '{4'b0100, 8'h03, 8'hFF, 2'b01, 4'b0100};
        tbl[5]  = '{4'b0000, 8'hFF, 8'hFF, 2'b00, 4'b0000};
        // Requester 0 held six cycles: grant every other cycle.
        tbl[6]  = '{4'b0001, 8'h01, 8'hFF, 2'b01, 4'b0001};
        tbl[7]  = '{4'b0001, 8'hFF, 8'hFF, 2'b00, 4'b0000};
        tbl[8]  = '{4'b0001, 8'h01, 8'hFF, 2'b01, 4'b0001};
        tbl[9]  = '{4'b0001, 8'hFF, 8'hFF, 2'b00, 4'b0000};
        tbl[10] = '{4'b0001, 8'h01, 8'hFF, 2'b01, 4'b0001};
        tbl[11] = '{4'b0001, 8'hFF, 8'hFF, 2'b00, 4'b0000};
        // Grant 1 and 2 (pointer -> 3), then wrap scan 3 -> 0 (pointer -> 1).
        tbl[12] = '{4'b0110, 8'h02, 8'h03, 2'b11, 4'b0110};
        tbl[13] = '{4'b1001, 8'h04, 8'h01, 2'b11, 4'b1001};
        tbl[14] = '{4'b1111, 8'h02, 8'h03, 2'b11, 4'b0110};
        // Late arrival: requester 1 rises while requester 0 is being served.
        tbl[15] = '{4'b0001, 8'h01, 8'hFF, 2'b01, 4'b0001};
        tbl[16] = '{4'b0011, 8'h02, 8'hFF, 2'b01, 4'b0010};
        tbl[17] = '{4'b0000, 8'hFF, 8'hFF, 2'b00, 4'b0000};

        // Reset state.
        rst_n = 1'b0;
        gb    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 8'hFF, 8'hFF, 2'b00, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            apply(tbl[i].gb);
            chk_all($sformatf("vec%0d", i), tbl[i].s0, tbl[i].s1, tbl[i].gv, tbl[i].gvec);
        end

        // Asynchronous reset mid-cycle while a grant is on the bus.
        apply(4'b1111);
        chk_all("pre_rst", 8'h03, 8'h04, 2'b11, 4'b1100);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 8'hFF, 8'hFF, 2'b00, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("post_rst", 8'h01, 8'h02, 2'b11, 4'b0011);
        m_ptr  = 0;
        m_cool = '0;
        model_step(4'b1111);

        // Random requests against the reference model, with occasional
        // mid-cycle resets.
        for (int c = 0; c < 600; c++) begin
            logic [N-1:0] v;
            v = N'($urandom);
            if ($urandom_range(0, 3) == 0) v = 4'b1111;
            @(negedge clk);
            rst_n = 1'b1;
            gb = v;
            @(posedge clk);
            model_step(gb);
            #1;
            chk_all($sformatf("rand%0d", c), e_s0, e_s1, e_gv, e_gvec);
            if ($urandom_range(0, 39) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk_all($sformatf("rand_rst%0d", c), 8'hFF, 8'hFF, 2'b00, 4'b0000);
                m_ptr  = 0;
                m_cool = '0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
